// File: rtl/param_alu_if.sv
// Operand/result bundle for param_alu. The requester side drives start/op/operands;
// the ALU side returns handshake pulses, the result and the status flags.
interface param_alu_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             i_carry;
  logic             wait_sig;
  logic             finish_sig;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             error_div_by_zero;

  modport master (
    output start, op, data0, data1, i_carry,
    input  wait_sig, finish_sig, result, carry, overflow, zero, negative, error_div_by_zero
  );

  modport slave (
    input  start, op, data0, data1, i_carry,
    output wait_sig, finish_sig, result, carry, overflow, zero, negative, error_div_by_zero
  );
endinterface

// File: rtl/param_alu.sv
// Parameterised ALU: single-cycle arithmetic/logic ops plus a multi-cycle
// restoring divider (unsigned, and optionally signed via magnitudes).
module param_alu #(
  parameter int WIDTH      = 64,
  parameter bit SIGNED_DIV = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  param_alu_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_ADC    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_SBB    = 4'd4;
  localparam logic [3:0] OP_MUL    = 4'd5;
  localparam logic [3:0] OP_AND    = 4'd6;
  localparam logic [3:0] OP_OR     = 4'd7;
  localparam logic [3:0] OP_XOR    = 4'd8;
  localparam logic [3:0] OP_BSET   = 4'd9;
  localparam logic [3:0] OP_BRESET = 4'd10;
  localparam logic [3:0] OP_DIV    = 4'd11;
  localparam logic [3:0] OP_MOD    = 4'd12;
  localparam logic [3:0] OP_DIVS   = 4'd13;
  localparam logic [3:0] OP_MODS   = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e state_r, state_nx_s;

  logic [WIDTH-1:0] result_r;
  logic             carry_r, ovf_flag_r, zero_r, neg_flag_r, err_r;

  logic [WIDTH-1:0] quo_r, rem_r, dvs_r;
  logic [IDX_W-1:0] cnt_r;
  logic             mod_r, negq_r, negr_r, sovf_r;

  logic             cin_s;
  logic [WIDTH:0]   sum_s, diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [IDX_W-1:0] bidx_s;
  logic [WIDTH-1:0] bit_mask_s;

  logic             is_udiv_s, is_sdiv_s, is_div_s, is_mod_s, b_zero_s;
  logic             accept_s, div_go_s, div_last_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;

  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s, alu_v_s, alu_err_s, alu_we_s;

  logic [WIDTH:0]   trial_s;
  logic             qbit_s;
  logic [WIDTH-1:0] quo_nx_s, rem_nx_s, q_fin_s, r_fin_s, div_res_s;

  assign cin_s      = ((bus.op == OP_ADC) || (bus.op == OP_SBB)) ? bus.i_carry : 1'b0;
  assign sum_s      = {1'b0, bus.data0} + {1'b0, bus.data1} + {{WIDTH{1'b0}}, cin_s};
  assign diff_s     = {1'b0, bus.data0} - {1'b0, bus.data1} - {{WIDTH{1'b0}}, cin_s};
  assign prod_s     = {{WIDTH{1'b0}}, bus.data0} * {{WIDTH{1'b0}}, bus.data1};
  assign bidx_s     = bus.data1[IDX_W-1:0];
  assign bit_mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << bidx_s;

  assign is_udiv_s  = (bus.op == OP_DIV) || (bus.op == OP_MOD);
  assign is_sdiv_s  = SIGNED_DIV && ((bus.op == OP_DIVS) || (bus.op == OP_MODS));
  assign is_div_s   = is_udiv_s || is_sdiv_s;
  assign is_mod_s   = (bus.op == OP_MOD) || (bus.op == OP_MODS);
  assign b_zero_s   = (bus.data1 == {WIDTH{1'b0}});

  assign accept_s   = (state_r == ST_IDLE) && bus.start;
  assign div_go_s   = accept_s && is_div_s && !b_zero_s;
  assign div_last_s = (state_r == ST_DIVIDE) && (cnt_r == CNT_LAST);

  // Signed divides run on magnitudes; signs are reapplied at completion
  assign a_mag_s = (is_sdiv_s && bus.data0[WIDTH-1]) ? neg_f(bus.data0) : bus.data0;
  assign b_mag_s = (is_sdiv_s && bus.data1[WIDTH-1]) ? neg_f(bus.data1) : bus.data1;

  // One restoring-division step: shift in the next dividend bit and trial-subtract
  always_comb begin
    trial_s  = {rem_r, quo_r[WIDTH-1]} - {1'b0, dvs_r};
    qbit_s   = ~trial_s[WIDTH];
    quo_nx_s = {quo_r[WIDTH-2:0], qbit_s};
    if (qbit_s) begin
      rem_nx_s = trial_s[WIDTH-1:0];
    end else begin
      rem_nx_s = {rem_r[WIDTH-2:0], quo_r[WIDTH-1]};
    end
    q_fin_s   = negq_r ? neg_f(quo_nx_s) : quo_nx_s;
    r_fin_s   = negr_r ? neg_f(rem_nx_s) : rem_nx_s;
    div_res_s = mod_r ? r_fin_s : q_fin_s;
  end

  // Single-cycle results, including the divide-by-zero short cut
  always_comb begin
    alu_res_s = result_r;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    alu_we_s  = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (bus.data0[WIDTH-1] == bus.data1[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != bus.data0[WIDTH-1]);
        alu_we_s  = 1'b1;
      end
      OP_SUB, OP_SBB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (bus.data0[WIDTH-1] != bus.data1[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != bus.data0[WIDTH-1]);
        alu_we_s  = 1'b1;
      end
      OP_MUL: begin
        alu_res_s = prod_s[WIDTH-1:0];
        alu_c_s   = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
        alu_we_s  = 1'b1;
      end
      OP_AND: begin
        alu_res_s = bus.data0 & bus.data1;
        alu_we_s  = 1'b1;
      end
      OP_OR: begin
        alu_res_s = bus.data0 | bus.data1;
        alu_we_s  = 1'b1;
      end
      OP_XOR: begin
        alu_res_s = bus.data0 ^ bus.data1;
        alu_we_s  = 1'b1;
      end
      OP_BSET: begin
        alu_res_s = bus.data0 | bit_mask_s;
        alu_we_s  = 1'b1;
      end
      OP_BRESET: begin
        alu_res_s = bus.data0 & ~bit_mask_s;
        alu_we_s  = 1'b1;
      end
      OP_DIV, OP_MOD, OP_DIVS, OP_MODS: begin
        if (is_div_s && b_zero_s) begin
          alu_res_s = is_mod_s ? bus.data0 : {WIDTH{1'b1}};
          alu_err_s = 1'b1;
          alu_we_s  = 1'b1;
        end else begin
          alu_we_s  = 1'b0;
        end
      end
      default: begin
        alu_we_s  = 1'b0;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!bus.start) begin
          state_nx_s = ST_IDLE;
        end else if (div_go_s) begin
          state_nx_s = ST_DIVIDE;
        end else begin
          state_nx_s = ST_FINISH;
        end
      end
      ST_DIVIDE: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_FINISH;
        end else begin
          state_nx_s = ST_DIVIDE;
        end
      end
      ST_FINISH: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Divider working registers: captured on the start edge, stepped while dividing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quo_r  <= {WIDTH{1'b0}};
      rem_r  <= {WIDTH{1'b0}};
      dvs_r  <= {WIDTH{1'b0}};
      cnt_r  <= {IDX_W{1'b0}};
      mod_r  <= 1'b0;
      negq_r <= 1'b0;
      negr_r <= 1'b0;
      sovf_r <= 1'b0;
    end else if (div_go_s) begin
      quo_r  <= a_mag_s;
      rem_r  <= {WIDTH{1'b0}};
      dvs_r  <= b_mag_s;
      cnt_r  <= {IDX_W{1'b0}};
      mod_r  <= is_mod_s;
      negq_r <= is_sdiv_s && (bus.data0[WIDTH-1] ^ bus.data1[WIDTH-1]);
      negr_r <= is_sdiv_s && bus.data0[WIDTH-1];
      sovf_r <= is_sdiv_s && (bus.data0 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                (bus.data1 == {WIDTH{1'b1}});
    end else if (state_r == ST_DIVIDE) begin
      quo_r  <= quo_nx_s;
      rem_r  <= rem_nx_s;
      cnt_r  <= cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

  // Result and flag registers; they change only when an operation completes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_r   <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      ovf_flag_r <= 1'b0;
      zero_r     <= 1'b0;
      neg_flag_r <= 1'b0;
      err_r      <= 1'b0;
    end else if (accept_s && alu_we_s) begin
      result_r   <= alu_res_s;
      carry_r    <= alu_c_s;
      ovf_flag_r <= alu_v_s;
      zero_r     <= (alu_res_s == {WIDTH{1'b0}});
      neg_flag_r <= alu_res_s[WIDTH-1];
      err_r      <= alu_err_s;
    end else if (div_last_s) begin
      result_r   <= div_res_s;
      carry_r    <= 1'b0;
      ovf_flag_r <= sovf_r;
      zero_r     <= (div_res_s == {WIDTH{1'b0}});
      neg_flag_r <= div_res_s[WIDTH-1];
      err_r      <= 1'b0;
    end
  end

  assign bus.wait_sig          = (state_r == ST_DIVIDE);
  assign bus.finish_sig        = (state_r == ST_FINISH);
  assign bus.result            = result_r;
  assign bus.carry             = carry_r;
  assign bus.overflow          = ovf_flag_r;
  assign bus.zero              = zero_r;
  assign bus.negative          = neg_flag_r;
  assign bus.error_div_by_zero = err_r;

endmodule

// File: tb/tb_param_alu.sv
// Directed self-checking bench for param_alu: a WIDTH=64 and a WIDTH=8 instance
// share clock and reset; each task drives one scenario and checks inline.
module tb_param_alu;
  logic clock;
  logic reset;
  int   errors;
  int   checks;

  param_alu_if #(.WIDTH(64)) b64 ();
  param_alu_if #(.WIDTH(8))  b8 ();

  param_alu #(.WIDTH(64), .SIGNED_DIV(1'b1)) dut64 (.clock(clock), .reset(reset), .bus(b64));
  param_alu #(.WIDTH(8),  .SIGNED_DIV(1'b1)) dut8  (.clock(clock), .reset(reset), .bus(b8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one op on the 64-bit ALU; report latency (cycles to finish) and wait_sig cycles
  task automatic op64(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                      input logic c, output int lat, output int waits);
    @(negedge clock);
    b64.start = 1'b1; b64.op = o; b64.data0 = a; b64.data1 = b; b64.i_carry = c;
    @(posedge clock); #1;
    b64.start = 1'b0;
    lat = 1; waits = 0;
    while (!b64.finish_sig && lat < 200) begin
      if (b64.wait_sig) waits++;
      @(posedge clock); #1;
      lat++;
    end
    @(posedge clock); #1;
  endtask

  task automatic op8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                     input logic c, output int lat, output int waits);
    @(negedge clock);
    b8.start = 1'b1; b8.op = o; b8.data0 = a; b8.data1 = b; b8.i_carry = c;
    @(posedge clock); #1;
    b8.start = 1'b0;
    lat = 1; waits = 0;
    while (!b8.finish_sig && lat < 200) begin
      if (b8.wait_sig) waits++;
      @(posedge clock); #1;
      lat++;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    checks++; if (b64.result !== 64'd0) begin errors++; $display("FAIL rst_res64 got %0h exp 0", b64.result); end
    checks++; if ({b64.carry, b64.overflow, b64.zero, b64.negative, b64.error_div_by_zero} !== 5'b00000) begin errors++; $display("FAIL rst_flags64 got %b exp 00000", {b64.carry, b64.overflow, b64.zero, b64.negative, b64.error_div_by_zero}); end
    checks++; if ({b64.wait_sig, b64.finish_sig, b8.wait_sig, b8.finish_sig} !== 4'b0000) begin errors++; $display("FAIL rst_hs got %b exp 0000", {b64.wait_sig, b64.finish_sig, b8.wait_sig, b8.finish_sig}); end
    checks++; if (b8.result !== 8'd0) begin errors++; $display("FAIL rst_res8 got %0h exp 0", b8.result); end
  endtask

  task automatic test_add_sub();
    int lat, w;
    op64(4'd1, 64'd6, 64'd3, 1'b0, lat, w);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat got %0d exp 1", lat); end
    checks++; if (b64.result !== 64'd9) begin errors++; $display("FAIL add_res got %0h exp 9", b64.result); end
    checks++; if ({b64.carry, b64.overflow, b64.zero, b64.negative, b64.error_div_by_zero} !== 5'b00000) begin errors++; $display("FAIL add_flags got %b exp 00000", {b64.carry, b64.overflow, b64.zero, b64.negative, b64.error_div_by_zero}); end
    op64(4'd3, 64'd3, 64'd6, 1'b0, lat, w);
    checks++; if (b64.result !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL sub_res got %0h exp fffffffffffffffd", b64.result); end
    checks++; if ({b64.carry, b64.overflow, b64.zero, b64.negative} !== 4'b1001) begin errors++; $display("FAIL sub_flags got %b exp 1001", {b64.carry, b64.overflow, b64.zero, b64.negative}); end
    op8(4'd2, 8'hFF, 8'h00, 1'b1, lat, w);
    checks++; if ({b8.result, b8.carry, b8.overflow, b8.zero} !== {8'h00, 3'b101}) begin errors++; $display("FAIL adc got %0h/%b exp 00/101", b8.result, {b8.carry, b8.overflow, b8.zero}); end
    op8(4'd1, 8'h7F, 8'h01, 1'b0, lat, w);
    checks++; if ({b8.result, b8.carry, b8.overflow, b8.negative} !== {8'h80, 3'b011}) begin errors++; $display("FAIL add_ovf got %0h/%b exp 80/011", b8.result, {b8.carry, b8.overflow, b8.negative}); end
    op8(4'd4, 8'h80, 8'h00, 1'b1, lat, w);
    checks++; if ({b8.result, b8.carry, b8.overflow} !== {8'h7F, 2'b01}) begin errors++; $display("FAIL sbb got %0h/%b exp 7f/01", b8.result, {b8.carry, b8.overflow}); end
  endtask

  task automatic test_div64();
    int lat, w;
    op64(4'd11, 64'd7, 64'd3, 1'b0, lat, w);
    checks++; if (w !== 64) begin errors++; $display("FAIL div_wait got %0d exp 64", w); end
    checks++; if (lat !== 65) begin errors++; $display("FAIL div_lat got %0d exp 65", lat); end
    checks++; if (b64.result !== 64'd2) begin errors++; $display("FAIL div_res got %0h exp 2", b64.result); end
    op64(4'd12, 64'd7, 64'd3, 1'b0, lat, w);
    checks++; if ({b64.result, b64.carry, b64.error_div_by_zero} !== {64'd1, 2'b00}) begin errors++; $display("FAIL mod_res got %0h exp 1", b64.result); end
  endtask

  task automatic test_signed_div8();
    int lat, w;
    op8(4'd13, 8'hF9, 8'h02, 1'b0, lat, w);
    checks++; if (lat !== 9) begin errors++; $display("FAIL divs_lat got %0d exp 9", lat); end
    checks++; if ({b8.result, b8.overflow, b8.negative} !== {8'hFD, 2'b01}) begin errors++; $display("FAIL divs_res got %0h/%b exp fd/01", b8.result, {b8.overflow, b8.negative}); end
    op8(4'd14, 8'hF9, 8'h02, 1'b0, lat, w);
    checks++; if (b8.result !== 8'hFF) begin errors++; $display("FAIL mods_res got %0h exp ff", b8.result); end
    op8(4'd13, 8'h80, 8'hFF, 1'b0, lat, w);
    checks++; if ({b8.result, b8.overflow} !== {8'h80, 1'b1}) begin errors++; $display("FAIL divs_min got %0h/%b exp 80/1", b8.result, b8.overflow); end
    op8(4'd14, 8'h80, 8'hFF, 1'b0, lat, w);
    checks++; if ({b8.result, b8.zero} !== {8'h00, 1'b1}) begin errors++; $display("FAIL mods_min got %0h/%b exp 00/1", b8.result, b8.zero); end
    op8(4'd12, 8'd200, 8'd7, 1'b0, lat, w);
    checks++; if (b8.result !== 8'd4) begin errors++; $display("FAIL mod8 got %0d exp 4", b8.result); end
  endtask

  task automatic test_div_zero();
    int lat, w;
    op8(4'd11, 8'd5, 8'd0, 1'b0, lat, w);
    checks++; if ({lat[3:0], w[3:0]} !== 8'h10) begin errors++; $display("FAIL dz_lat got lat=%0d waits=%0d exp 1/0", lat, w); end
    checks++; if ({b8.result, b8.error_div_by_zero} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL dz_div got %0h/%b exp ff/1", b8.result, b8.error_div_by_zero); end
    op8(4'd14, 8'h85, 8'd0, 1'b0, lat, w);
    checks++; if ({b8.result, b8.error_div_by_zero, b8.negative} !== {8'h85, 2'b11}) begin errors++; $display("FAIL dz_mods got %0h/%b exp 85/11", b8.result, {b8.error_div_by_zero, b8.negative}); end
    op8(4'd1, 8'd1, 8'd1, 1'b0, lat, w);
    checks++; if ({b8.result, b8.error_div_by_zero} !== {8'd2, 1'b0}) begin errors++; $display("FAIL dz_clear got %0h/%b exp 02/0", b8.result, b8.error_div_by_zero); end
  endtask

  task automatic test_logic();
    int lat, w;
    op8(4'd5, 8'h10, 8'h10, 1'b0, lat, w);
    checks++; if ({b8.result, b8.carry, b8.zero, b8.overflow} !== {8'h00, 3'b110}) begin errors++; $display("FAIL mul got %0h/%b exp 00/110", b8.result, {b8.carry, b8.zero, b8.overflow}); end
    op8(4'd9, 8'h00, 8'd9, 1'b0, lat, w);
    checks++; if (b8.result !== 8'h02) begin errors++; $display("FAIL bset got %0h exp 02", b8.result); end
    op8(4'd10, 8'hFF, 8'd3, 1'b0, lat, w);
    checks++; if (b8.result !== 8'hF7) begin errors++; $display("FAIL breset got %0h exp f7", b8.result); end
    op8(4'd6, 8'hF0, 8'h3C, 1'b0, lat, w);
    checks++; if (b8.result !== 8'h30) begin errors++; $display("FAIL and got %0h exp 30", b8.result); end
    op8(4'd7, 8'hF0, 8'h3C, 1'b0, lat, w);
    checks++; if (b8.result !== 8'hFC) begin errors++; $display("FAIL or got %0h exp fc", b8.result); end
    op8(4'd8, 8'hF0, 8'h3C, 1'b0, lat, w);
    checks++; if ({b8.result, b8.negative} !== {8'hCC, 1'b1}) begin errors++; $display("FAIL xor got %0h exp cc", b8.result); end
    op8(4'd0, 8'h11, 8'h22, 1'b0, lat, w);
    checks++; if ({lat[3:0], b8.result} !== {4'd1, 8'hCC}) begin errors++; $display("FAIL nop got lat=%0d res=%0h exp 1/cc", lat, b8.result); end
    op8(4'd15, 8'h00, 8'h00, 1'b0, lat, w);
    checks++; if ({b8.result, b8.negative, b8.zero} !== {8'hCC, 2'b10}) begin errors++; $display("FAIL rsvd got %0h exp cc", b8.result); end
  endtask

  task automatic test_back_to_back();
    int fin, cyc;
    @(negedge clock);
    b8.start = 1'b1; b8.op = 4'd11; b8.data0 = 8'd100; b8.data1 = 8'd7;
    @(posedge clock); #1;
    b8.start = 1'b0; b8.data0 = 8'd3; b8.data1 = 8'd1;
    fin = 0; cyc = 1;
    repeat (2) begin @(posedge clock); #1; cyc++; end
    b8.start = 1'b1; b8.op = 4'd1;
    while (!b8.finish_sig && cyc < 100) begin @(posedge clock); #1; cyc++; end
    if (b8.finish_sig) fin++;
    checks++; if (cyc !== 9) begin errors++; $display("FAIL b2b_lat got %0d exp 9", cyc); end
    checks++; if (b8.result !== 8'd14) begin errors++; $display("FAIL b2b_res got %0d exp 14", b8.result); end
    @(posedge clock); #1;
    if (b8.finish_sig) fin++;
    b8.start = 1'b0;
    repeat (4) begin @(posedge clock); #1; if (b8.finish_sig) fin++; end
    checks++; if (fin !== 1) begin errors++; $display("FAIL b2b_finishes got %0d exp 1", fin); end
    checks++; if (b8.result !== 8'd14) begin errors++; $display("FAIL b2b_hold got %0d exp 14", b8.result); end
  endtask

  task automatic test_reset_mid_div();
    int fin, w, lat;
    @(negedge clock);
    b64.start = 1'b1; b64.op = 4'd11; b64.data0 = 64'd7; b64.data1 = 64'd3;
    @(posedge clock); #1;
    b64.start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if ({b64.result, b64.wait_sig, b64.finish_sig} !== {64'd0, 2'b00}) begin errors++; $display("FAIL midrst got res=%0h wait=%b fin=%b exp 0/0/0", b64.result, b64.wait_sig, b64.finish_sig); end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    fin = 0; w = 0;
    repeat (70) begin @(posedge clock); #1; if (b64.finish_sig) fin++; if (b64.wait_sig) w++; end
    checks++; if ({fin, w} !== {32'd0, 32'd0}) begin errors++; $display("FAIL midrst_abort got fin=%0d wait=%0d exp 0/0", fin, w); end
    op64(4'd1, 64'd6, 64'd3, 1'b0, lat, w);
    checks++; if ({lat[7:0], b64.result} !== {8'd1, 64'd9}) begin errors++; $display("FAIL post_rst got lat=%0d res=%0h exp 1/9", lat, b64.result); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1;
    b64.start = 1'b0; b64.op = 4'd0; b64.data0 = 64'd0; b64.data1 = 64'd0; b64.i_carry = 1'b0;
    b8.start = 1'b0;  b8.op = 4'd0;  b8.data0 = 8'd0;   b8.data1 = 8'd0;   b8.i_carry = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    test_add_sub();
    test_div64();
    test_signed_div8();
    test_div_zero();
    test_logic();
    test_back_to_back();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 64: operand and result width in bits; legal values are powers of two, 8 to 64.
REQ-002 SHALL provide parameter SIGNED_DIV, default 1: when 1 the signed DIVS/MODS opcodes are implemented; when 0 they complete as NOP.
REQ-003 SHALL provide port clock  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL provide port op  input  4  opcode: 0 NOP, 1 ADD, 2 ADC, 3 SUB, 4 SBB, 5 MUL, 6 AND, 7 OR, 8 XOR, 9 BSET, 10 BRESET, 11 DIV, 12 MOD, 13 DIVS, 14 MODS, 15 reserved (acts as NOP).
REQ-007 SHALL provide ports data0, data1  input  WIDTH  operands A and B; i_carry  input  1  carry/borrow in for ADC/SBB.
REQ-008 SHALL provide port wait_sig  output  1  high while a multi-cycle divide is in progress.
REQ-009 SHALL provide port finish_sig  output  1  one-cycle pulse: result and flags valid.
REQ-010 SHALL provide ports result  output  WIDTH; carry, overflow, zero, negative  output  1 each; error_div_by_zero  output  1.

Function
REQ-011 SHALL implement states IDLE, DIVIDE, FINISH; IDLE->FINISH on start with non-divide op or divide by zero; IDLE->DIVIDE on start with divide op and B!=0; DIVIDE->FINISH after WIDTH iterations; FINISH->IDLE unconditionally.
REQ-012 SHALL register operands and op on the start edge; operand changes afterwards have no effect on the operation in flight.
REQ-013 SHALL assert finish_sig for exactly one cycle, in FINISH: one cycle after the start edge for single-cycle ops, WIDTH+1 cycles after the start edge for DIV/MOD/DIVS/MODS.
REQ-014 SHALL ignore start in DIVIDE and FINISH (no queueing); start in the FINISH cycle is dropped.
REQ-015 SHALL hold result and all flags stable from their update until the next operation completes.
REQ-016 ADD/ADC: result = A+B(+i_carry) mod 2^WIDTH; carry = unsigned carry-out; overflow = signed overflow.
REQ-017 SUB/SBB: result = A-B(-i_carry) mod 2^WIDTH; carry = 1 on unsigned borrow; overflow = signed overflow.
REQ-018 MUL: result = low WIDTH bits of the unsigned product; carry = 1 if the high WIDTH bits are nonzero; overflow = 0.
REQ-019 AND/OR/XOR: bitwise result; BSET: A with bit B[log2(WIDTH)-1:0] set; BRESET: that bit cleared; carry = overflow = 0.
REQ-020 DIV/MOD: unsigned restoring division, one quotient bit per cycle; DIV result = quotient, MOD result = remainder.
REQ-021 DIVS/MODS: operate on magnitudes, quotient truncates toward zero, remainder takes the sign of A; MIN/-1 gives quotient MIN, remainder 0, overflow = 1.
REQ-022 Divide by zero (B==0, any divide op): no iterations; DIV/DIVS result = all ones, MOD/MODS result = A; error_div_by_zero = 1; latency 1.
REQ-023 error_div_by_zero SHALL be 0 for every other completion.
REQ-024 For every completing op except NOP, zero = (result==0) and negative = result[WIDTH-1]; divides have carry = 0.
REQ-025 NOP/reserved: finish_sig pulses after 1 cycle; result and all flags retain previous values.
REQ-026 wait_sig SHALL equal (state==DIVIDE).

Reset
REQ-027 Reset asserted at any time, including mid-divide, SHALL force IDLE within the same cycle, abort the operation without finish_sig, and drive result=0, all flags=0, wait_sig=0, finish_sig=0.
REQ-028 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-029 WIDTH=64, ADD A=6 B=3 -> finish_sig 1 cycle after start, result=9, all flags 0; SUB A=3 B=6 -> result=2^64-3, carry=1, negative=1.
REQ-030 WIDTH=64, DIV A=7 B=3 -> wait_sig high 64 cycles, finish_sig at cycle 65, result=2; MOD -> result=1.
REQ-031 WIDTH=8, DIVS A=-7 B=2 -> result=-3 (0xFD); MODS -> result=-1 (0xFF); DIVS A=0x80 B=0xFF -> result=0x80, overflow=1.
REQ-032 WIDTH=8, DIV A=5 B=0 -> finish_sig after 1 cycle, result=0xFF, error_div_by_zero=1; a following ADD -> error_div_by_zero=0.
REQ-033 WIDTH=8, MUL A=0x10 B=0x10 -> result=0x00, carry=1, zero=1; BSET A=0 B=9 -> result=0x02.
REQ-034 Reset asserted mid-DIV -> outputs 0 immediately, no finish_sig; start during DIVIDE -> ignored, one finish_sig only.
